// File: rtl/seg7_pkg.sv
// Shared constants and payload types for the 6-digit seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_ERR   = 7'h79;
  localparam logic [6:0] SEG_ALL   = 7'h7F;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;

  localparam logic [2:0] DIG_U10   = 3'd0;
  localparam logic [2:0] DIG_U01   = 3'd1;
  localparam logic [2:0] DIG_L1000 = 3'd2;
  localparam logic [2:0] DIG_L0100 = 3'd3;
  localparam logic [2:0] DIG_L0010 = 3'd4;
  localparam logic [2:0] DIG_L0001 = 3'd5;

  // One coherent display frame as captured from the core.
  typedef struct packed {
    logic [7:0] u10;
    logic [7:0] u01;
    logic [7:0] l1000;
    logic [7:0] l0100;
    logic [7:0] l0010;
    logic [7:0] l0001;
    logic       point;
    logic       col;
  } seg7_frame_t;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_ERR;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Core-to-display bundle: ASCII digits and flags in, multiplexed segment drive out.
// Carries lamp_test only when SEG7_LAMP_TEST_EN is defined.
interface seg7_scan_driver_if;
  logic [7:0] upper10;
  logic [7:0] upper01;
  logic [7:0] lower1000;
  logic [7:0] lower0100;
  logic [7:0] lower0010;
  logic [7:0] lower0001;
  logic       point;
  logic       col;
`ifdef SEG7_LAMP_TEST_EN
  logic       lamp_test;
`endif
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digit_en;
  logic       col_led;
  logic       frame_sync;

  modport master (
`ifdef SEG7_LAMP_TEST_EN
    output lamp_test,
`endif
    output upper10, upper01, lower1000, lower0100, lower0010, lower0001,
    output point, col,
    input  seg, dp, digit_en, col_led, frame_sync
  );

  modport slave (
`ifdef SEG7_LAMP_TEST_EN
    input  lamp_test,
`endif
    input  upper10, upper01, lower1000, lower0100, lower0010, lower0001,
    input  point, col,
    output seg, dp, digit_en, col_led, frame_sync
  );
endinterface

// File: rtl/seg7_ascii_decode.sv
// ASCII byte to seven-segment pattern {g,f,e,d,c,b,a}; blank forces all segments off.
module seg7_ascii_decode
  import seg7_pkg::*;
(
  input  logic [7:0] ascii,
  input  logic       blank,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_ERR;
    if (blank) begin
      seg_c = SEG_BLANK;
    end else if (ascii >= ASCII_ZERO && ascii <= (ASCII_ZERO + 8'd9)) begin
      seg_c = seg_of_digit(4'(ascii - ASCII_ZERO));
    end else if (ascii == ASCII_SPACE) begin
      seg_c = SEG_BLANK;
    end else if (ascii == ASCII_DASH) begin
      seg_c = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit common-cathode driver with per-frame snapshot, ghost blanking
// and leading-zero suppression. Optional lamp test under SEG7_LAMP_TEST_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLANK_CYC = 1
) (
  input logic              clock,
  input logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        digit_idx;
  logic              first_q;
  seg7_frame_t       shadow;
  seg7_frame_t       in_frame_c;
  logic              slot_last_c;
  logic              snap_c;
  logic              blank_win_c;
  logic [7:0]        byte_c;
  logic              sup_c;
  logic              l1000_sup_c;
  logic              l0100_sup_c;
  logic [6:0]        dec_seg_c;
  logic              lamp_c;

  logic [6:0] seg_q;
  logic       dp_q;
  logic [5:0] digit_en_q;
  logic       col_led_q;
  logic       frame_sync_q;

  assign in_frame_c = '{u10:   bus.upper10,   u01:   bus.upper01,
                        l1000: bus.lower1000, l0100: bus.lower0100,
                        l0010: bus.lower0010, l0001: bus.lower0001,
                        point: bus.point,     col:   bus.col};

  assign slot_last_c = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign snap_c      = first_q | (slot_last_c && digit_idx == DIG_L0001);
  assign blank_win_c = (slot_cnt < SLOT_W'(BLANK_CYC));

  // Slot and digit scan counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      digit_idx <= DIG_U10;
    end else if (slot_last_c) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_L0001) ? DIG_U10 : digit_idx + 3'd1;
    end else begin
      slot_cnt  <= slot_cnt + SLOT_W'(1);
    end
  end

  // Shadow frame: captured at the frame boundary and once right after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q <= 1'b1;
      shadow  <= '{u10: ASCII_SPACE, u01: ASCII_SPACE, l1000: ASCII_SPACE,
                   l0100: ASCII_SPACE, l0010: ASCII_SPACE, l0001: ASCII_SPACE,
                   point: 1'b0, col: 1'b0};
    end else begin
      first_q <= 1'b0;
      if (snap_c) shadow <= in_frame_c;
    end
  end

  // Lower leading zeros are kept in time mode so "00:05" stays readable.
  assign l1000_sup_c = !shadow.col && (shadow.l1000 == ASCII_ZERO);
  assign l0100_sup_c = l1000_sup_c && (shadow.l0100 == ASCII_ZERO);

  always_comb begin
    byte_c = ASCII_SPACE;
    sup_c  = 1'b0;
    case (digit_idx)
      DIG_U10:   begin byte_c = shadow.u10;   sup_c = (shadow.u10 == ASCII_ZERO); end
      DIG_U01:   byte_c = shadow.u01;
      DIG_L1000: begin byte_c = shadow.l1000; sup_c = l1000_sup_c; end
      DIG_L0100: begin byte_c = shadow.l0100; sup_c = l0100_sup_c; end
      DIG_L0010: byte_c = shadow.l0010;
      DIG_L0001: byte_c = shadow.l0001;
      default:   ;
    endcase
  end

  seg7_ascii_decode u_decode (
    .ascii (byte_c),
    .blank (sup_c),
    .seg_c (dec_seg_c)
  );

`ifdef SEG7_LAMP_TEST_EN
  logic lamp_hold_q;

  // Keeps the lamp test lit until the current slot ends after deassertion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             lamp_hold_q <= 1'b0;
    else if (bus.lamp_test) lamp_hold_q <= 1'b1;
    else if (slot_last_c)   lamp_hold_q <= 1'b0;
  end

  assign lamp_c = bus.lamp_test | lamp_hold_q;
`else
  assign lamp_c = 1'b0;
`endif

  // Registered display drive, one clock behind the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
      col_led_q    <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      frame_sync_q <= (digit_idx == DIG_U10) && (slot_cnt == '0);
      col_led_q    <= shadow.col | lamp_c;
      if (blank_win_c) begin
        seg_q      <= SEG_BLANK;
        dp_q       <= 1'b0;
        digit_en_q <= '0;
      end else begin
        seg_q      <= lamp_c ? SEG_ALL : dec_seg_c;
        dp_q       <= lamp_c | ((digit_idx == DIG_L0010) && shadow.point);
        digit_en_q <= 6'b1 << digit_idx;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.col_led    = col_led_q;
  assign bus.frame_sync = frame_sync_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage of the bicycle computer. Consumes the six ASCII digit bytes plus the point and colon flags produced by the core.
- Drives one time-multiplexed 6-digit common-cathode seven-segment display with per-slot ghost blanking, leading-zero suppression and a per-frame coherent snapshot.
- Runs on the 2048 Hz system clock.

Parameters:
SCAN_DIV, 4, clocks per digit slot (frame = 6*SCAN_DIV clocks; 24 -> 85.3 Hz refresh); legal range 2..64
BLANK_CYC, 1, dark clocks at the start of every slot; must be < SCAN_DIV

Ports:
clock  input  1  system clock, 2048 Hz
reset  input  1  asynchronous, active-low (0 = reset)
upper10  input  8  ASCII speed tens
upper01  input  8  ASCII speed units
lower1000  input  8  ASCII value thousands
lower0100  input  8  ASCII value hundreds
lower0010  input  8  ASCII value tens
lower0001  input  8  ASCII value units
point  input  1  decimal point after lower0010 (DAY/AVS)
col  input  1  colon between lower0100 and lower0010 (TIM)
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
dp  output  1  decimal-point segment, active-high
digit_en  output  6  one-hot digit select, active-high; bit0=upper10 ... bit5=lower0001
col_led  output  1  colon LED, static
frame_sync  output  1  one-cycle pulse at the first clock of slot 0

Behaviour:
- Reset values: seg=0, dp=0, digit_en=0, col_led=0, frame_sync=0. Counters slot_cnt=0 and digit_idx=0. Shadow bytes all 0x20 (blank); shadow flags 0.
- Scan counters:
  - slot_cnt counts 0..SCAN_DIV-1.
  - digit_idx advances 0..5 and wraps to 0 when slot_cnt==SCAN_DIV-1.
- Snapshot: all eight inputs are latched into shadow registers on the clock edge where digit_idx==5 and slot_cnt==SCAN_DIV-1, and also on the first clock after reset release. Input changes mid-frame never tear a frame. Worst-case input-to-display latency is one frame + 2 clocks.
- Outputs are registered, one clock behind the counters.
  - While slot_cnt < BLANK_CYC: digit_en=0, seg=0, dp=0.
  - Otherwise: digit_en=1<<digit_idx, and seg/dp come from the shadow digit.
- frame_sync=1 for exactly one clock: the registered cycle corresponding to digit_idx=0, slot_cnt=0.
- ASCII decode:
  - '0'..'9' -> 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
  - 0x20 -> 00. '-' (0x2D) -> 40.
  - Any other byte -> 'E' (79).
- Leading-zero suppression, applied to shadow bytes, decoded as blank:
  - upper10 is blanked when it is '0'.
  - When col=0: lower1000 is blanked when '0'; lower0100 is blanked when '0' and lower1000 is blanked. lower0010 and lower0001 are never suppressed.
  - When col=1 there is no lower suppression (the time display shows 00:05).
- dp=1 only in slot 4 (lower0010), only after the blank window, and only when shadow point=1.
- col_led = shadow col, updated at snapshot only, and not gated by blanking.
- If point and col are both 1, both are shown. Suppression follows the col=1 rule.
- Asynchronous reset mid-frame: outputs go dark immediately. Scanning restarts at slot 0 after release.

Optional Feature:
- SEG7_LAMP_TEST_EN
  - Defined: adds input lamp_test (1 bit, synchronous). While it is 1, every non-blanked slot drives seg=7F, dp=1, and col_led=1; scanning and snapshots continue unchanged. Deasserting it returns to normal display on the next slot boundary.
  - Not defined: the port is absent and there is no lamp-test logic.

Decomposition:
- Package seg7_pkg holds:
  - the segment pattern constants (SEG_0..SEG_9, SEG_BLANK, SEG_DASH, SEG_ERR);
  - the ASCII constants ASCII_ZERO=0x30, ASCII_SPACE=0x20, ASCII_DASH=0x2D;
  - the digit index constants DIG_U10..DIG_L0001.
- One combinational sub-module, seg7_ascii_decode: 8-bit ASCII plus a blank flag in, 7-bit seg out. The driver uses one instance on the muxed shadow byte.

Test Plan:
- Reset low for 3 clocks, then release with inputs "12","0345", point=1, col=0 -> after the first snapshot:
  - digit_en sequence 01,02,04,08,10,20, each active SCAN_DIV-BLANK_CYC=3 clocks after 1 dark clock;
  - seg: 06 for upper10, 5B for upper01, 00 for lower1000 (suppressed), 4F, 66, 6D;
  - dp=1 only during slot 4.
- Inputs "05","0007", col=1 -> upper10 blank; lower digits 3F,3F,3F,07 (no suppression); col_led=1.
- Inputs "00","0000", col=0 -> lower1000 and lower0100 blank; lower0010=3F; lower0001=3F; upper10 blank; upper01=3F.
- Change lower0001 from '3' to '4' while slot 2 is active -> slot 5 of the current frame still shows 4F; the next frame shows 66; frame_sync period = 24 clocks.
- Input byte 0x41 on upper01, and 0x2D on lower1000 -> seg 79 and 40 respectively.
- Assert reset during slot 3 -> all outputs 0 within the same timestep; after release, the first lit slot is digit_en=01 at clock BLANK_CYC+1.
